nios_sys_ram_test_master: RTL and testbench

NIOS_SYS_RAM_TEST_MASTER -- requirements
Module: nios_sys_ram_test_master

---
 rtl/nios_sys_ram_test_master.sv | 206 ++++++++++++++++++++
 tb/tb_nios_sys_ram_test_master.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_sys_ram_test_master.sv
`default_nettype none
// ============================================================================
//  Module      : nios_sys_ram_test_master
//  Description : Avalon-MM master that fills a word range of a RAM with an
//                incrementing pattern (seed + i) and/or reads it back,
//                counting mismatches and recording the first failing word.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios_sys_ram_test_master #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_word,
    input  logic [ADDR_W:0]   word_count,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W+1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ_REQ  = 3'd2,
        ST_READ_WAIT = 3'd3,
        ST_FINISH    = 3'd4
    } state_t;

    localparam logic [1:0]  c_MODE_FILL   = 2'b00;
    localparam logic [1:0]  c_MODE_VERIFY = 2'b01;
    localparam logic [15:0] c_ERR_MAX     = 16'hFFFF;

    state_t              r_state;
    state_t              w_next;

    // Run parameters, frozen at the start edge
    logic [1:0]          r_mode;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_count;
    logic [DATA_W-1:0]   r_seed;

    // Element index; one bit wider than the address so 2^ADDR_W words fit
    logic [ADDR_W:0]     r_idx;
    logic [15:0]         r_err;
    logic [ADDR_W-1:0]   r_first;
    logic                r_pass;

    logic [ADDR_W:0]     w_idx_inc;
    logic                w_last;
    logic [ADDR_W-1:0]   w_word;
    logic [DATA_W-1:0]   w_pattern;
    logic                w_has_read;
    logic                w_mismatch;

    assign w_idx_inc  = r_idx + (ADDR_W+1)'(1);
    assign w_last     = (w_idx_inc == r_count);
    // Word index wraps naturally at 2^ADDR_W
    assign w_word     = r_base + r_idx[ADDR_W-1:0];
    assign w_pattern  = r_seed + DATA_W'(r_idx);
    // Mode 01 is verify only; 00 is fill only; 10 and 11 do both
    assign w_has_read = (r_mode != c_MODE_FILL);
    assign w_mismatch = (avm_readdata != w_pattern);

    assign avm_byteenable = 4'hF;
    assign avm_address    = (avm_read || avm_write) ? {w_word, 2'b00} : '0;
    assign avm_writedata  = avm_write ? w_pattern : '0;
    assign err_count      = r_err;
    assign first_err_addr = r_first;
    assign pass           = r_pass;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and bus strobes; strobes depend on state only
    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        done      = 1'b0;
        avm_read  = 1'b0;
        avm_write = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (word_count == '0) begin
                        w_next = ST_FINISH;
                    end else if (mode == c_MODE_VERIFY) begin
                        w_next = ST_READ_REQ;
                    end else begin
                        w_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                avm_write = 1'b1;
                if (!avm_waitrequest && w_last) begin
                    w_next = w_has_read ? ST_READ_REQ : ST_FINISH;
                end
            end
            ST_READ_REQ: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    w_next = ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: begin
                if (avm_readdatavalid) begin
                    w_next = w_last ? ST_FINISH : ST_READ_REQ;
                end
            end
            ST_FINISH: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

    // Run parameter capture, index stepping and result bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode  <= '0;
            r_base  <= '0;
            r_count <= '0;
            r_seed  <= '0;
            r_idx   <= '0;
            r_err   <= '0;
            r_first <= '0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode  <= mode;
                        r_base  <= base_word;
                        r_count <= word_count;
                        r_seed  <= seed;
                        r_idx   <= '0;
                        r_err   <= '0;
                        r_first <= '0;
                        // An empty run goes straight to FINISH as a pass
                        r_pass  <= (word_count == '0);
                    end
                end
                ST_WRITE: begin
                    if (!avm_waitrequest) begin
                        if (w_last) begin
                            // Read phase restarts at element 0
                            r_idx <= '0;
                            if (!w_has_read) begin
                                r_pass <= 1'b1;
                            end
                        end else begin
                            r_idx <= w_idx_inc;
                        end
                    end
                end
                ST_READ_WAIT: begin
                    if (avm_readdatavalid) begin
                        if (w_mismatch) begin
                            if (r_err != c_ERR_MAX) begin
                                r_err <= r_err + 16'd1;
                            end
                            // Saturation never returns to zero, so zero means "no error yet"
                            if (r_err == '0) begin
                                r_first <= w_word;
                            end
                        end
                        if (w_last) begin
                            r_pass <= (r_err == '0) && !w_mismatch;
                        end else begin
                            r_idx <= w_idx_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nios_sys_ram_test_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios_sys_ram_test_master
//  Description : Self-checking bench for nios_sys_ram_test_master with an
//                Avalon-MM memory slave and a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nios_sys_ram_test_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [11:0] base_word;
    logic [12:0] word_count;
    logic [31:0] seed;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [11:0] first_err_addr;
    logic [13:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    nios_sys_ram_test_master #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .mode              (mode),
        .base_word         (base_word),
        .word_count        (word_count),
        .seed              (seed),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .err_count         (err_count),
        .first_err_addr    (first_err_addr),
        .avm_address       (avm_address),
        .avm_byteenable    (avm_byteenable),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Memory and transaction-level model
    logic [31:0] mem [0:4095];
    logic [13:0] q_wa [$];
    logic [31:0] q_wd [$];
    logic [13:0] q_ra [$];
    logic [13:0] wr_log [$];
    int          wr_cyc [$];
    int          exp_err;
    logic [11:0] exp_first;
    bit          stall_en = 1'b0;
    bit          noise_en = 1'b0;
    int          cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_pass"},  pass, 0);
        chk({tag, "_err"},   err_count, 0);
        chk({tag, "_first"}, first_err_addr, 0);
        chk({tag, "_addr"},  avm_address, 0);
        chk({tag, "_wdata"}, avm_writedata, 0);
        chk({tag, "_read"},  avm_read, 0);
        chk({tag, "_write"}, avm_write, 0);
    endtask

    // Build the expected bus transactions and result, then pulse start
    task automatic launch(input logic [1:0] m, input logic [11:0] b,
                          input logic [12:0] n, input logic [31:0] s);
        logic [11:0] w;
        exp_err = 0;
        exp_first = '0;
        q_wa.delete(); q_wd.delete(); q_ra.delete(); wr_log.delete(); wr_cyc.delete();
        for (int i = 0; i < int'(n); i++) begin
            w = b + 12'(i);
            if (m != 2'b01) begin
                q_wa.push_back({w, 2'b00});
                q_wd.push_back(s + 32'(i));
            end
            if (m != 2'b00) begin
                q_ra.push_back({w, 2'b00});
                if (m == 2'b01 && mem[w] != s + 32'(i)) begin
                    if (exp_err == 0) exp_first = w;
                    exp_err++;
                end
            end
        end
        start = 1'b1; mode = m; base_word = b; word_count = n; seed = s;
    endtask

    task automatic wait_done(input bit poke, input logic [12:0] n, output int cycles);
        bit got;
        got = 1'b0;
        cycles = 0;
        while (!got && cycles < 5000) begin
            @(negedge clk);
            cycles++;
            start = poke && (cycles == 3);
            if (cycles == 1) begin
                // Inputs change after capture; the run must not notice
                mode = 2'($urandom); base_word = 12'($urandom);
                word_count = 13'($urandom); seed = $urandom;
                if (n != 0) begin
                    chk("pass_cleared", pass, 0);
                    chk("err_cleared", err_count, 0);
                    chk("first_cleared", first_err_addr, 0);
                end
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: no done after %0d cycles, required a done pulse", cycles);
        end else begin
            chk("busy_at_done", busy, 1);
            chk("pass", pass, exp_err == 0);
            chk("err_count", err_count, exp_err);
            chk("first_err_addr", first_err_addr, exp_first);
            chk("writes_left", q_wa.size(), 0);
            chk("reads_left", q_ra.size(), 0);
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("idle_after_done", busy, 0);
            chk("pass_held", pass, exp_err == 0);
        end
    endtask

    // Memory slave and per-cycle compare against the expected transactions
    initial begin : slave
        bit          pend, pw, pr, prev_reset;
        int          pend_cnt;
        logic [31:0] pend_data, pd;
        logic [13:0] pa;
        pend = 0; pend_cnt = 0; pend_data = '0; pw = 0; pr = 0; pa = '0; pd = '0;
        prev_reset = 1'b1;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            chk("rw_exclusive", avm_read & avm_write, 0);
            chk("byteenable", avm_byteenable, 4'hF);
            if (!avm_write) chk("wdata_zero_idle", avm_writedata, 0);
            if (pw && !prev_reset) begin
                chk("stall_write_held", avm_write, 1);
                chk("stall_waddr_stable", avm_address, pa);
                chk("stall_wdata_stable", avm_writedata, pd);
            end
            if (pr && !prev_reset) begin
                chk("stall_read_held", avm_read, 1);
                chk("stall_raddr_stable", avm_address, pa);
            end
            avm_readdatavalid = 1'b0;
            avm_readdata = '0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = pend_data;
                    pend = 1'b0;
                end
            end else if (noise_en && $urandom_range(0, 3) == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = $urandom;
            end
            avm_waitrequest = stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (!reset) begin
                if (avm_write && !avm_waitrequest) begin
                    if (q_wa.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: got write at 0x%0h, required none", avm_address);
                    end else begin
                        chk("write_addr", avm_address, q_wa.pop_front());
                        chk("write_data", avm_writedata, q_wd.pop_front());
                    end
                    mem[avm_address[13:2]] = avm_writedata;
                    wr_log.push_back(avm_address);
                    wr_cyc.push_back(cyc);
                end
                if (avm_read && !avm_waitrequest) begin
                    if (q_ra.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_read: got read at 0x%0h, required none", avm_address);
                    end else begin
                        chk("read_addr", avm_address, q_ra.pop_front());
                    end
                    pend = 1'b1;
                    pend_cnt = stall_en ? $urandom_range(1, 3) : 1;
                    pend_data = mem[avm_address[13:2]];
                end
            end
            pw = avm_write && avm_waitrequest;
            pr = avm_read && avm_waitrequest;
            pa = avm_address;
            pd = avm_writedata;
            prev_reset = reset;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        reset = 1'b1; start = 1'b0; mode = '0; base_word = '0; word_count = '0; seed = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        // Fill then verify, zero-wait: 8 writes back to back, 8 reads of 2 cycles
        launch(2'b10, 12'd0, 13'd8, 32'h100);
        wait_done(1'b0, 13'd8, c);
        chk("fv8_cycles", c, 25);
        chk("fv8_wlog_size", wr_log.size(), 8);
        if (wr_log.size() == 8) begin
            chk("fv8_first_addr", wr_log[0], 14'h0);
            chk("fv8_last_addr", wr_log[7], 14'h1C);
            chk("fv8_back_to_back", wr_cyc[7] - wr_cyc[0], 7);
        end
        chk("fv8_mem7", mem[7], 32'h107);
        chk("fv8_pass", pass, 1);

        // Verify with one corrupted word
        mem[2] = 32'hDEAD;
        launch(2'b01, 12'd0, 13'd4, 32'h100);
        wait_done(1'b0, 13'd4, c);
        chk("ver_err_lit", err_count, 1);
        chk("ver_first_lit", first_err_addr, 2);
        chk("ver_pass_lit", pass, 0);

        // Same verify under stalls, random latency and stray readdatavalid
        stall_en = 1'b1; noise_en = 1'b1;
        launch(2'b01, 12'd0, 13'd4, 32'h100);
        wait_done(1'b0, 13'd4, c);
        chk("stall_ver_err_lit", err_count, 1);
        chk("stall_ver_first_lit", first_err_addr, 2);
        stall_en = 1'b0; noise_en = 1'b0;

        // Fill only
        launch(2'b00, 12'd100, 13'd5, 32'hABCD0000);
        wait_done(1'b0, 13'd5, c);
        chk("fill_pass_lit", pass, 1);
        chk("fill_err_lit", err_count, 0);
        chk("fill_mem104", mem[104], 32'hABCD0004);

        // Address and pattern wrap
        launch(2'b10, 12'd4094, 13'd4, 32'hFFFFFFFE);
        wait_done(1'b0, 13'd4, c);
        chk("wrap_wlog_size", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            chk("wrap_a0", wr_log[0], 14'h3FF8);
            chk("wrap_a1", wr_log[1], 14'h3FFC);
            chk("wrap_a2", wr_log[2], 14'h0);
            chk("wrap_a3", wr_log[3], 14'h4);
        end
        chk("wrap_mem0", mem[0], 32'h0);

        // Empty run
        launch(2'b10, 12'd5, 13'd0, 32'h1);
        wait_done(1'b0, 13'd0, c);
        chk("empty_cycles", c, 1);
        chk("empty_pass", pass, 1);

        // Stalled fill+verify with a start poked mid-run, then stalled verify
        stall_en = 1'b1; noise_en = 1'b1;
        launch(2'b11, 12'd300, 13'd20, 32'hCAFE0000);
        wait_done(1'b1, 13'd20, c);
        launch(2'b01, 12'd300, 13'd20, 32'hCAFE0000);
        wait_done(1'b0, 13'd20, c);
        chk("stall_fv_pass", pass, 1);
        stall_en = 1'b0; noise_en = 1'b0;

        // Reset in the middle of a long fill, after an ignored start
        launch(2'b00, 12'd0, 13'd200, 32'd5);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", busy, 1);
        start = 1'b1; mode = 2'b01; base_word = 12'd77; word_count = 13'd3;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_still_writing", avm_write, 1);
        reset = 1'b1;
        @(negedge clk);
        q_wa.delete(); q_wd.delete(); q_ra.delete();
        chk_reset_vals("midrun_reset");
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("no_restart_busy", busy, 0);
            chk("no_restart_strobe", avm_read | avm_write, 0);
        end

        // Normal operation after the abort
        launch(2'b10, 12'd10, 13'd3, 32'd7);
        wait_done(1'b0, 13'd3, c);
        chk("post_reset_pass", pass, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
